// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory request arbiter: requester ownership,
// FSM states and access-length codes understood by the memory controller.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LD   = 2'd2,
    OWN_ST   = 2'd3
  } owner_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [2:0] LEN_B = 3'd0;
  localparam logic [2:0] LEN_H = 3'd1;
  localparam logic [2:0] LEN_W = 3'd2;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection: store > load > fetch, with a starved fetch jumping the
// queue. A flush suppresses speculative requesters but never a store.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_valid_i,
  input  logic   l_valid_i,
  input  logic   s_valid_i,
  input  logic   starve_i,
  input  logic   clear_i,
  output owner_e win_o
);

  always_comb begin
    win_o = OWN_NONE;
    if (starve_i && i_valid_i && !clear_i) win_o = OWN_IF;
    else if (s_valid_i)                    win_o = OWN_ST;
    else if (l_valid_i && !clear_i)        win_o = OWN_LD;
    else if (i_valid_i && !clear_i)        win_o = OWN_IF;
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Single-port arbiter in front of the byte-serial memory controller.
// Command outputs are registered; completion pulses and abort follow mc_ready/RoB_clear directly.
module mem_request_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        RoB_clear,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_data,
  input  logic        l_valid,
  input  logic [31:0] l_addr,
  input  logic [2:0]  l_len,
  output logic        l_ready,
  output logic [31:0] l_data,
  input  logic        s_valid,
  input  logic [31:0] s_addr,
  input  logic [2:0]  s_len,
  input  logic [31:0] s_value,
  output logic        s_done,
  output logic        mc_waiting,
  output logic        mc_wr,
  output logic [2:0]  mc_len,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_value,
  output logic        mc_abort,
  input  logic        mc_ready,
  input  logic [31:0] mc_result
);

  localparam int             CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

  state_e        state_q;
  owner_e        owner_q;
  logic [CW-1:0] starve_q, starve_d;
  logic          waiting_q, wr_q;
  logic [2:0]    len_q;
  logic [31:0]   addr_q, value_q;

  owner_e win;
  logic   starve, spec_own, abort, done;

  assign starve = (starve_q == LIMIT);

  mem_arb_pick u_pick (
    .i_valid_i (i_valid),
    .l_valid_i (l_valid),
    .s_valid_i (s_valid),
    .starve_i  (starve),
    .clear_i   (RoB_clear),
    .win_o     (win)
  );

  // Abort only applies in BUSY; DRAIN is always a store and ignores flushes.
  assign spec_own = (owner_q == OWN_IF) || (owner_q == OWN_LD);
  assign abort    = rdy_in && (state_q == S_BUSY) && RoB_clear && spec_own;
  assign done     = rdy_in && (state_q != S_IDLE) && mc_ready && !abort;

  assign i_ready    = done && (owner_q == OWN_IF);
  assign l_ready    = done && (owner_q == OWN_LD);
  assign s_done     = done && (owner_q == OWN_ST);
  assign i_data     = i_ready ? mc_result : 32'h0;
  assign l_data     = l_ready ? mc_result : 32'h0;
  assign mc_abort   = abort;
  assign mc_waiting = waiting_q;
  assign mc_wr      = wr_q;
  assign mc_len     = len_q;
  assign mc_addr    = addr_q;
  assign mc_value   = value_q;

  // Data grants only count against fetch while fetch is actually waiting.
  always_comb begin
    starve_d = starve_q;
    if (win == OWN_IF || !i_valid)     starve_d = '0;
    else if (win != OWN_NONE && !starve) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_NONE;
      starve_q  <= '0;
      waiting_q <= 1'b0;
      wr_q      <= 1'b0;
      len_q     <= 3'd0;
      addr_q    <= 32'h0;
      value_q   <= 32'h0;
    end else if (rdy_in) begin
      case (state_q)
        S_IDLE: begin
          starve_q <= starve_d;
          if (win != OWN_NONE) begin
            state_q   <= S_BUSY;
            owner_q   <= win;
            waiting_q <= 1'b1;
            case (win)
              OWN_ST: begin
                wr_q <= 1'b1; len_q <= s_len; addr_q <= s_addr; value_q <= s_value;
              end
              OWN_LD: begin
                wr_q <= 1'b0; len_q <= l_len; addr_q <= l_addr; value_q <= 32'h0;
              end
              default: begin
                wr_q <= 1'b0; len_q <= LEN_W; addr_q <= i_addr; value_q <= 32'h0;
              end
            endcase
          end
        end
        S_BUSY, S_DRAIN: begin
          if (abort) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_NONE;
            waiting_q <= 1'b0;
            starve_q  <= '0;
          end else if (done) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_NONE;
            waiting_q <= 1'b0;
          end else if (state_q == S_BUSY && RoB_clear && owner_q == OWN_ST) begin
            state_q <= S_DRAIN;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          owner_q   <= OWN_NONE;
          waiting_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed plus randomized checks of mem_request_arbiter against a
// transaction-level model of pending requesters and the fetch starvation count.
module tb_mem_request_arbiter;

  localparam int LIM = 4;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, RoB_clear;
  logic        i_valid, l_valid, s_valid;
  logic [31:0] i_addr, l_addr, s_addr, s_value;
  logic [2:0]  l_len, s_len;
  logic        i_ready, l_ready, s_done;
  logic [31:0] i_data, l_data;
  logic        mc_waiting, mc_wr, mc_abort, mc_ready;
  logic [2:0]  mc_len;
  logic [31:0] mc_addr, mc_value, mc_result;

  mem_request_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .RoB_clear(RoB_clear),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_data(i_data),
    .l_valid(l_valid), .l_addr(l_addr), .l_len(l_len), .l_ready(l_ready), .l_data(l_data),
    .s_valid(s_valid), .s_addr(s_addr), .s_len(s_len), .s_value(s_value), .s_done(s_done),
    .mc_waiting(mc_waiting), .mc_wr(mc_wr), .mc_len(mc_len), .mc_addr(mc_addr),
    .mc_value(mc_value), .mc_abort(mc_abort), .mc_ready(mc_ready), .mc_result(mc_result)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0, n_fail = 0;

  // Model: outstanding request per requester (0 none, 1 fetch, 2 load, 3 store)
  bit          iv, lv, sv;
  logic [31:0] ia, la, sa, sval;
  logic [2:0]  llen, slen;
  int          sc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic drive();
    i_valid = iv; i_addr = ia;
    l_valid = lv; l_addr = la; l_len = llen;
    s_valid = sv; s_addr = sa; s_len = slen; s_value = sval;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_waiting"}, 32'(mc_waiting), 0);
    chk({tag, "_wr"},      32'(mc_wr), 0);
    chk({tag, "_len"},     32'(mc_len), 0);
    chk({tag, "_addr"},    mc_addr, 0);
    chk({tag, "_value"},   mc_value, 0);
    chk({tag, "_pulses"},  32'({i_ready, l_ready, s_done, mc_abort}), 0);
    chk({tag, "_data"},    i_data | l_data, 0);
  endtask

  // IDLE cycle: predict the winner from pending requests, then check the command.
  task automatic grant_step(input bit clr, output int w);
    w = 0;
    if (sc == LIM && iv && !clr) w = 1;
    else if (sv)                 w = 3;
    else if (lv && !clr)         w = 2;
    else if (iv && !clr)         w = 1;
    if (w == 1 || !iv) sc = 0;
    else if (w != 0 && sc < LIM) sc++;
    drive();
    RoB_clear = clr;
    tick();
    RoB_clear = 1'b0;
    chk("grant_waiting", 32'(mc_waiting), 32'(w != 0));
    if (w == 3) begin
      chk("st_wr", 32'(mc_wr), 1); chk("st_len", 32'(mc_len), 32'(slen));
      chk("st_addr", mc_addr, sa); chk("st_value", mc_value, sval);
    end else if (w == 2) begin
      chk("ld_wr", 32'(mc_wr), 0); chk("ld_len", 32'(mc_len), 32'(llen));
      chk("ld_addr", mc_addr, la);
    end else if (w == 1) begin
      chk("if_wr", 32'(mc_wr), 0); chk("if_len", 32'(mc_len), 2);
      chk("if_addr", mc_addr, ia);
    end
  endtask

  // BUSY phase: mode 0 completes, 1 flushes, 2 flushes together with mc_ready.
  task automatic finish_txn(input int w, input int delay, input int mode, input logic [31:0] res);
    bit ab, dn;
    logic [31:0] hold_addr;
    hold_addr = mc_addr;
    repeat (delay) begin
      tick();
      chk("busy_waiting", 32'(mc_waiting), 1);
      chk("busy_addr", mc_addr, hold_addr);
    end
    ab = (mode != 0) && (w != 3);
    dn = !ab && (mode != 1);
    RoB_clear = (mode != 0);
    mc_ready  = (mode != 1);
    mc_result = res;
    #1;
    chk("abort", 32'(mc_abort), 32'(ab));
    chk("i_ready", 32'(i_ready), 32'(dn && w == 1));
    chk("l_ready", 32'(l_ready), 32'(dn && w == 2));
    chk("s_done",  32'(s_done),  32'(dn && w == 3));
    if (dn && w == 1) chk("i_data", i_data, res);
    if (dn && w == 2) chk("l_data", l_data, res);
    tick();
    RoB_clear = 1'b0;
    mc_ready  = 1'b0;
    if (ab || dn) begin
      chk("end_waiting", 32'(mc_waiting), 0);
      if (ab) sc = 0;
      if (w == 1) iv = 0; else if (w == 2) lv = 0; else sv = 0;
    end else begin
      repeat ($urandom_range(1, 3)) begin
        RoB_clear = 1'($urandom);
        #1;
        chk("drain_abort", 32'(mc_abort), 0);
        chk("drain_sdone", 32'(s_done), 0);
        tick();
        chk("drain_waiting", 32'(mc_waiting), 1);
      end
      RoB_clear = 1'b0;
      mc_ready  = 1'b1;
      #1;
      chk("drain_done", 32'(s_done), 1);
      tick();
      mc_ready = 1'b0;
      chk("drain_end", 32'(mc_waiting), 0);
      sv = 0;
    end
    drive();
  endtask

  initial begin
    int w, m;
    iv = 0; lv = 0; sv = 0; ia = 0; la = 0; sa = 0; sval = 0; llen = 0; slen = 0; sc = 0;
    rst_in = 1'b1; rdy_in = 1'b1; RoB_clear = 1'b0; mc_ready = 1'b0; mc_result = 32'h0;
    drive();
    tick(); tick();
    chk_all_zero("reset");
    rst_in = 1'b0;

    // Fetch only, completion five cycles after command
    iv = 1; ia = 32'h1000;
    grant_step(0, w);
    finish_txn(w, 4, 0, 32'h00112233);

    // Store and load together, fetch pending throughout
    iv = 1; ia = 32'h2000; lv = 1; la = 32'h3001; llen = 3'd0;
    sv = 1; sa = 32'h4000; slen = 3'd2; sval = 32'hCAFEF00D;
    repeat (3) begin
      grant_step(0, w);
      finish_txn(w, 1, 0, $urandom);
    end

    // Back-to-back loads against a pending fetch: starvation guard
    iv = 1; ia = 32'h5000;
    repeat (5) begin
      if (!lv) begin lv = 1; la = $urandom; llen = 3'd1; end
      grant_step(0, w);
      finish_txn(w, 0, 0, $urandom);
    end
    iv = 0;

    // Flush during load; queued store goes next and drains through a flush
    lv = 1; la = 32'h6000; llen = 3'd2;
    grant_step(0, w);
    sv = 1; sa = 32'h7000; slen = 3'd1; sval = 32'h0000BEEF;
    drive();
    finish_txn(w, 1, 1, 32'h0);
    grant_step(0, w);
    finish_txn(w, 1, 1, 32'h0);

    // rdy_in low mid-BUSY freezes everything, including mc_ready sampling
    iv = 1; ia = 32'h8000;
    grant_step(0, w);
    tick();
    rdy_in = 1'b0; mc_ready = 1'b1; mc_result = 32'h13572468;
    repeat (3) begin
      #1;
      chk("frozen_iready", 32'(i_ready), 0);
      tick();
      chk("frozen_waiting", 32'(mc_waiting), 1);
      chk("frozen_addr", mc_addr, 32'h8000);
    end
    rdy_in = 1'b1;
    #1;
    chk("thaw_iready", 32'(i_ready), 1);
    chk("thaw_idata", i_data, 32'h13572468);
    tick();
    mc_ready = 1'b0; iv = 0; drive();
    chk("thaw_waiting", 32'(mc_waiting), 0);

    // Reset mid-BUSY
    sv = 1; sa = 32'h9000; slen = 3'd2; sval = 32'h11111111;
    grant_step(0, w);
    rst_in = 1'b1;
    tick();
    chk_all_zero("midrst");
    rst_in = 1'b0; sv = 0; sc = 0; drive();
    tick();

    // Randomized traffic
    repeat (300) begin
      if (!iv && $urandom_range(0, 1) == 1) begin iv = 1; ia = $urandom & 32'hFFFF_FFFC; end
      if (!lv && $urandom_range(0, 1) == 1) begin lv = 1; la = $urandom; llen = 3'($urandom_range(0, 2)); end
      if (!sv && $urandom_range(0, 3) == 0) begin
        sv = 1; sa = $urandom; slen = 3'($urandom_range(0, 2)); sval = $urandom;
      end
      grant_step($urandom_range(0, 7) == 0, w);
      if (w != 0) begin
        m = $urandom_range(0, 7);
        finish_txn(w, $urandom_range(0, 3), (m < 5) ? 0 : (m < 7) ? 1 : 2, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
